uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single SoC UART transmitter between NUM_REQ byte-stream requesters (e.g. CPU console,
//  boot monitor, debug/status reporter). Round-robin grant, held for a whole line (until EOL_CHAR)
//  so text from different sources is never interleaved mid-line. Sits between requesters and UART TX.
// PARAMETERS
//  NUM_REQ         2      number of requesters (2..8)
//  EOL_CHAR        8'h0A  byte that ends a line and releases the grant
//  TIMEOUT_CYCLES  16000  idle cycles before a held grant is forcibly released (1 ms @ 16 MHz)
// PORTS
//  clk          in   1          system clock
//  reset_ni     in   1          asynchronous active-low reset
//  req_data_i   in   8*NUM_REQ  byte from requester k at [8k+7:8k]
//  req_valid_i  in   NUM_REQ    requester k has a byte
//  req_ready_o  out  NUM_REQ    byte k accepted when valid&ready
//  tx_data_o    out  8          byte to UART TX
//  tx_valid_o   out  1          tx_data_o valid
//  tx_ready_i   in   1          UART TX accepts byte (valid&ready = transfer)
//  grant_o      out  NUM_REQ    one-hot current owner, 0 when IDLE
// BEHAVIOUR
//  Reset: req_ready_o=0, tx_valid_o=0, tx_data_o=0, grant_o=0, state=IDLE, last=NUM_REQ-1 (req 0 wins first).
//  Output stage: one-entry register (buf). tx_valid_o=buf_full; buf drains on tx_valid_o&tx_ready_i.
//  States: IDLE -> LOCKED -> RELEASE -> IDLE.
//  - IDLE: if any req_valid_i, pick first k set scanning last+1, last+2, ... (mod NUM_REQ);
//    grant_o registered next cycle, state=LOCKED, idle counter=0. No ready asserted in IDLE.
//    Latency: valid at cycle 0 -> grant_o and ready at cycle 1 (buf empty) -> accept at cycle 1.
//  - LOCKED: req_ready_o[g] = !buf_full | tx_ready_i; all other ready bits 0. Accepted byte loads buf.
//    Accepted byte == EOL_CHAR -> RELEASE (the EOL byte itself is sent).
//    Idle counter: +1 each cycle granted req_valid_i=0, cleared on any accept; saturates.
//  - RELEASE: all ready=0; when buf empty (or draining this cycle) -> IDLE, last=g, grant_o=0.
//  Back-to-back: ready may stay high every cycle while tx_ready_i=1 (full throughput, 1 byte/cycle).
//  Simultaneous drain+load of buf in same cycle: buf keeps valid, takes new byte.
//  Requester dropping valid mid-line: grant held (until EOL or timeout); others starve meanwhile.
//  tx_data_o stable while tx_valid_o=1 & tx_ready_i=0. Non-granted valids ignored, never lost-accepted.
//  Reset mid-operation: buf discarded, any partial line lost, all outputs to reset values.
//  Counter width $clog2(TIMEOUT_CYCLES+1); round-robin index $clog2(NUM_REQ) bits, wraps NUM_REQ-1 -> 0.
// CONFIGURATION
//  UART_ARB_TIMEOUT_EN defined: LOCKED with idle counter == TIMEOUT_CYCLES -> RELEASE (partial line
//    ends, grant passes on). Counter logic present.
//  Not defined: no counter; grant released only by EOL_CHAR (a requester that never sends EOL_CHAR
//    holds the UART indefinitely). TIMEOUT_CYCLES unused.
// TESTING
//  1 Reset, req0 sends "AB\n" with tx_ready_i=1 -> grant_o=01 at cycle 1, tx bytes 41,42,0A in order,
//    grant_o=00 after 0A drains.
//  2 req0,req1 both valid from reset, each "X\n"/"Y\n" -> output exactly 58,0A,59,0A (req0 first),
//    then next round req1 wins before req0 when both request again.
//  3 req0 sends "12", req1 valid during it, req0 then "\n" -> 31,32,0A uninterrupted, then req1 data.
//  4 tx_ready_i=0 for 5 cycles with buf full -> tx_data_o stable, req_ready_o[g]=0, no byte lost/dup.
//  5 UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8: req0 sends 41 then idles, req1 waiting -> release after
//    8 idle cycles, req1 granted; without macro, req1 never granted until req0 sends 0A.
//  6 reset_ni low mid-line (buf full) -> outputs 0 immediately (async); after release req0 wins first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, line-locked sharing of one UART TX between NUM_REQ byte streams.
// Optional macro UART_ARB_TIMEOUT_EN: a held grant is released after TIMEOUT_CYCLES idle cycles.
module uart_tx_arbiter #(
  parameter int         NUM_REQ        = 2,
  parameter logic [7:0] EOL_CHAR       = 8'h0A,
  parameter int         TIMEOUT_CYCLES = 16000
) (
  input  logic                 clk,
  input  logic                 reset_ni,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [7:0]           tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic [NUM_REQ-1:0]   grant_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_LOCKED  = 2'b01;
  localparam logic [1:0] ST_RELEASE = 2'b10;

  logic [1:0]         state_q;
  logic [IDX_W-1:0]   last_q;
  logic [IDX_W-1:0]   gidx_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_vld;

  logic [7:0]         buf_data_p0;
  logic               buf_vld_p0;

  logic [7:0]         sel_data;
  logic               sel_valid;
  logic               ready_g;
  logic               accept;
  logic               drain;
  logic               eol_hit;
  logic               timeout_hit;

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(NUM_REQ - 1)) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

  // Round-robin pick: scan last+1, last+2, ... so the previous owner goes to the back.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand     = last_q;
    pick_idx = last_q;
    pick_vld = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = rr_next(cand);
      if (!pick_vld && req_valid_i[cand]) begin
        pick_idx = cand;
        pick_vld = 1'b1;
      end
    end
  end

  assign sel_data    = req_data_i[{gidx_q, 3'b000} +: 8];
  assign sel_valid   = req_valid_i[gidx_q];
  assign ready_g     = (state_q == ST_LOCKED) && (!buf_vld_p0 || tx_ready_i);
  assign req_ready_o = grant_q & {NUM_REQ{ready_g}};
  assign accept      = ready_g && sel_valid;
  assign drain       = buf_vld_p0 && tx_ready_i;
  assign eol_hit     = accept && (sel_data == EOL_CHAR);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] idle_cnt_q;

  assign timeout_hit = (state_q == ST_LOCKED) && (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Counts cycles the owner holds the grant without offering a byte; saturates at the limit.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      idle_cnt_q <= '0;
    end else if (state_q == ST_IDLE || accept) begin
      idle_cnt_q <= '0;
    end else if (state_q == ST_LOCKED && !sel_valid && !timeout_hit) begin
      idle_cnt_q <= idle_cnt_q + 1'b1;
    end
  end
`else
  logic timeout_unused;

  assign timeout_hit    = 1'b0;
  assign timeout_unused = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      last_q  <= IDX_W'(NUM_REQ - 1);
      gidx_q  <= '0;
      grant_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            state_q <= ST_LOCKED;
            gidx_q  <= pick_idx;
            grant_q <= NUM_REQ'(1) << pick_idx;
          end
        end
        ST_LOCKED: begin
          if (eol_hit || timeout_hit) begin
            state_q <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          // Hand the UART on only once the final byte of the line has left the buffer.
          if (!buf_vld_p0 || drain) begin
            state_q <= ST_IDLE;
            last_q  <= gidx_q;
            grant_q <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  // Output stage p0: one-entry buffer; a load in the same cycle as a drain keeps it full.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      buf_vld_p0  <= 1'b0;
      buf_data_p0 <= '0;
    end else if (accept) begin
      buf_vld_p0  <= 1'b1;
      buf_data_p0 <= sel_data;
    end else if (drain) begin
      buf_vld_p0  <= 1'b0;
    end
  end

  assign tx_valid_o = buf_vld_p0;
  assign tx_data_o  = buf_data_p0;
  assign grant_o    = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: line-level arbitration model plus directed byte streams.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int         NUM_REQ = 2;
  localparam logic [7:0] EOL     = 8'h0A;
  localparam int         TO      = 8;

  logic                 clk = 1'b0;
  logic                 reset_ni;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [NUM_REQ-1:0]   grant;

  int checks = 0;
  int errors = 0;

  logic [7:0] src0[$];
  logic [7:0] src1[$];
  logic [7:0] exp_q[$];
  logic [7:0] out_log[$];
  logic [7:0] lit[$];

  int                 last_m;
  int                 idle_m;
  bit                 line_done;
  bit                 prev_stall;
  logic [7:0]         prev_data;
  logic [NUM_REQ-1:0] prev_grant;
  logic [NUM_REQ-1:0] prev_rv;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .EOL_CHAR(EOL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset_ni(reset_ni),
    .req_data_i(req_data),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .tx_data_o(tx_data),
    .tx_valid_o(tx_valid),
    .tx_ready_i(tx_ready),
    .grant_o(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line-level model: owner, round-robin pointer, in-flight bytes and line completion.
  always @(negedge clk) begin : cmp
    logic [NUM_REQ-1:0] exp_grant;
    logic [NUM_REQ-1:0] exp_rdy;
    logic [NUM_REQ-1:0] acc;
    logic [7:0]         e;
    int                 g;
    bit                 rel;
    if (!reset_ni) begin
      exp_q.delete();
      last_m     = NUM_REQ - 1;
      idle_m     = 0;
      line_done  = 1'b0;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_grant = '0;
      prev_rv    = '0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", tx_valid, 1);
        chk("stall_data", tx_data, prev_data);
      end
      if (prev_grant == '0) begin
        exp_grant = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
          if (exp_grant == '0 && prev_rv[(last_m + i) % NUM_REQ]) begin
            exp_grant[(last_m + i) % NUM_REQ] = 1'b1;
          end
        end
        chk("arb_grant", grant, exp_grant);
        if (grant != '0) begin
          line_done = 1'b0;
          idle_m    = 0;
        end
      end else if (grant == '0) begin
        chk("release_after_line", line_done, 1);
        chk("release_drained", exp_q.size(), 0);
        for (int k = 0; k < NUM_REQ; k++) begin
          if (prev_grant[k]) last_m = k;
        end
      end else begin
        chk("grant_hold", grant, prev_grant);
      end
      exp_rdy = (grant != '0 && !line_done && (!tx_valid || tx_ready)) ? grant : '0;
      chk("req_ready", req_ready, exp_rdy);
      chk("tx_valid", tx_valid, exp_q.size() != 0);
      if (tx_valid && tx_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("tx_byte", tx_data, e);
        out_log.push_back(tx_data);
      end
      acc = req_valid & req_ready;
      rel = 1'b0;
      g   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (grant[k]) g = k;
        if (acc[k]) begin
          exp_q.push_back(req_data[8*k +: 8]);
          if (req_data[8*k +: 8] == EOL) rel = 1'b1;
        end
      end
`ifdef UART_ARB_TIMEOUT_EN
      if (grant != '0 && !line_done) begin
        if (idle_m == TO) rel = 1'b1;
        if (acc != '0) idle_m = 0;
        else if (!req_valid[g] && idle_m < TO) idle_m++;
      end
`endif
      if (rel) line_done = 1'b1;
      prev_grant = grant;
      prev_rv    = req_valid;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  task automatic drive();
    req_valid[0]   = (src0.size() != 0);
    req_data[7:0]  = (src0.size() != 0) ? src0[0] : 8'h00;
    req_valid[1]   = (src1.size() != 0);
    req_data[15:8] = (src1.size() != 0) ? src1[0] : 8'h00;
  endtask

  task automatic tick();
    logic [NUM_REQ-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    if (acc[0] && src0.size() != 0) void'(src0.pop_front());
    if (acc[1] && src1.size() != 0) void'(src1.pop_front());
    drive();
  endtask

  task automatic wait_out(input int n, input string name);
    int cyc = 0;
    while (out_log.size() < n && cyc < 200) begin
      tick();
      cyc++;
    end
    chk({name, "_count"}, out_log.size(), n);
  endtask

  task automatic chk_log(input string name);
    chk({name, "_len"}, out_log.size(), lit.size());
    for (int i = 0; i < lit.size() && i < out_log.size(); i++) begin
      chk($sformatf("%s_byte%0d", name, i), out_log[i], lit[i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_ni  = 1'b0;
    tx_ready  = 1'b1;
    req_valid = '0;
    req_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_grant", grant, 0);

    // Single line from req0 at full throughput.
    src0 = '{8'h41, 8'h42, 8'h0A};
    drive();
    reset_ni = 1'b1;
    tick();
    chk("t1_grant_c1", grant, 2'b01);
    chk("t1_ready_c1", req_ready, 2'b01);
    wait_out(3, "t1");
    lit = '{8'h41, 8'h42, 8'h0A};
    chk_log("t1");
    chk("t1_grant_released", grant, 2'b00);

    // Both requesters valid from reset; req0 requests again after its first line.
    reset_ni = 1'b0;
    src0.delete();
    src1.delete();
    out_log.delete();
    src0 = '{8'h58, 8'h0A, 8'h5A, 8'h0A};
    src1 = '{8'h59, 8'h0A};
    drive();
    @(posedge clk);
    #1;
    reset_ni = 1'b1;
    tick();
    chk("t2_grant_c1", grant, 2'b01);
    wait_out(6, "t2");
    lit = '{8'h58, 8'h0A, 8'h59, 8'h0A, 8'h5A, 8'h0A};
    chk_log("t2");

    // Line held across a gap while req1 waits.
    out_log.delete();
    src0 = '{8'h31, 8'h32};
    drive();
    tick();
    chk("t3_grant", grant, 2'b01);
    src1 = '{8'h55, 8'h0A};
    drive();
    wait_out(2, "t3a");
    repeat (4) begin
      tick();
      chk("t3_hold", grant, 2'b01);
    end
    src0.push_back(8'h0A);
    drive();
    wait_out(5, "t3");
    lit = '{8'h31, 8'h32, 8'h0A, 8'h55, 8'h0A};
    chk_log("t3");

    // UART back-pressure with the buffer full.
    out_log.delete();
    tx_ready = 1'b0;
    src0 = '{8'h61, 8'h62, 8'h0A};
    drive();
    tick();
    chk("t4_grant", grant, 2'b01);
    tick();
    repeat (5) begin
      chk("t4_stall_ready", req_ready, 2'b00);
      chk("t4_stall_valid", tx_valid, 1);
      chk("t4_stall_data", tx_data, 8'h61);
      tick();
    end
    tx_ready = 1'b1;
    wait_out(3, "t4");
    lit = '{8'h61, 8'h62, 8'h0A};
    chk_log("t4");

    // Owner goes quiet mid-line while req1 waits.
    out_log.delete();
    src0 = '{8'h41};
    drive();
    wait_out(1, "t5a");
    src1 = '{8'h42, 8'h0A};
    drive();
`ifdef UART_ARB_TIMEOUT_EN
    wait_out(3, "t5");
    lit = '{8'h41, 8'h42, 8'h0A};
    chk_log("t5");
`else
    repeat (20) begin
      tick();
      chk("t5_hold", grant, 2'b01);
    end
    chk("t5_no_output", out_log.size(), 1);
    src0.push_back(8'h0A);
    drive();
    wait_out(4, "t5");
    lit = '{8'h41, 8'h0A, 8'h42, 8'h0A};
    chk_log("t5");
`endif

    // Asynchronous reset while a byte sits in the buffer.
    out_log.delete();
    tx_ready = 1'b0;
    src0 = '{8'h71, 8'h72, 8'h0A};
    drive();
    tick();
    chk("t6_grant", grant, 2'b01);
    tick();
    chk("t6_buf_full", tx_valid, 1);
    reset_ni = 1'b0;
    #1;
    chk("t6_async_tx_valid", tx_valid, 0);
    chk("t6_async_tx_data", tx_data, 0);
    chk("t6_async_grant", grant, 0);
    chk("t6_async_ready", req_ready, 0);
    src0.delete();
    src1.delete();
    out_log.delete();
    drive();
    repeat (2) @(posedge clk);
    #1;
    src0 = '{8'h51, 8'h0A};
    src1 = '{8'h52, 8'h0A};
    drive();
    tx_ready = 1'b1;
    reset_ni = 1'b1;
    tick();
    chk("t6_grant_after_reset", grant, 2'b01);
    wait_out(4, "t6");
    lit = '{8'h51, 8'h0A, 8'h52, 8'h0A};
    chk_log("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
